// File: rtl/uio_bus_arbiter_if.sv
// Bundle of requester handshakes and uio pad signals shared by the arbiter.
// The slave modport is the arbiter's view; master is the requesters' and pads' view.
interface uio_bus_arbiter_if;
  logic       req0;
  logic       dir0;
  logic [7:0] wdata0;
  logic       gnt0;
  logic       req1;
  logic       dir1;
  logic [7:0] wdata1;
  logic       gnt1;
  logic [7:0] rdata;
  logic       rvalid;
  logic       busy;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport slave (
    input  req0, dir0, wdata0, req1, dir1, wdata1, uio_in,
    output gnt0, gnt1, rdata, rvalid, busy, uio_out, uio_oe
  );

  modport master (
    output req0, dir0, wdata0, req1, dir1, wdata1, uio_in,
    input  gnt0, gnt1, rdata, rvalid, busy, uio_out, uio_oe
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pad bus between two requesters.
// Every grant is preceded by TA_CYCLES of bus turnaround with all output enables low,
// and each grant is limited to HOLD_MAX cycles so a continuous requester cannot starve the other.
module uio_bus_arbiter #(
  parameter int unsigned HOLD_MAX  = 8,
  parameter int unsigned TA_CYCLES = 1,
  parameter logic [7:0]  OE_MASK   = 8'hFF
) (
  input logic              clk,
  input logic              rst,
  input logic              ena,
  uio_bus_arbiter_if.slave bus
);

  localparam int unsigned HW = $clog2(HOLD_MAX + 1);
  localparam int unsigned TW = $clog2(TA_CYCLES + 1);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD_MAX - 1);
  localparam logic [TW-1:0] TaLast   = TW'(TA_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StTurn, StOwn} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          dir_q, dir_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] ta_q, ta_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  logic req_own, req_oth, winner, drive;

  assign req_own = owner_q ? bus.req1 : bus.req0;
  assign req_oth = owner_q ? bus.req0 : bus.req1;

  // State register; reset leaves last=1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      dir_q    <= 1'b0;
      hold_q   <= '0;
      ta_q     <= '0;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      dir_q    <= dir_d;
      hold_q   <= hold_d;
      ta_q     <= ta_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Next-state: arbitration, turnaround countdown, grant hold limit and read capture.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    dir_d    = dir_q;
    hold_d   = hold_q;
    ta_d     = ta_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    winner   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ena && (bus.req0 || bus.req1)) begin
          // Tie goes to whoever did not own the bus last.
          winner  = (bus.req0 && bus.req1) ? !last_q : bus.req1;
          owner_d = winner;
          dir_d   = winner ? bus.dir1 : bus.dir0;
          ta_d    = '0;
          state_d = StTurn;
        end
      end
      StTurn: begin
        if (ta_q == TaLast) begin
          if (req_own) begin
            state_d = StOwn;
            hold_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          ta_d = ta_q + 1'b1;
        end
      end
      StOwn: begin
        if (!dir_q) begin
          rdata_d  = bus.uio_in & OE_MASK;
          rvalid_d = 1'b1;
        end
        hold_d = hold_q + 1'b1;
        if (!req_own || (hold_q == HoldLast)) begin
          last_d = owner_q;
          if (req_oth) begin
            owner_d = !owner_q;
            dir_d   = owner_q ? bus.dir0 : bus.dir1;
            ta_d    = '0;
            state_d = StTurn;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Disabling the design releases the bus from any state.
    if (!ena) state_d = StIdle;
  end

  // Pad drive is gated by ena combinationally so release happens in the same cycle.
  assign drive = (state_q == StOwn) && dir_q && ena;

  assign bus.gnt0    = (state_q == StOwn) && !owner_q;
  assign bus.gnt1    = (state_q == StOwn) && owner_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.uio_oe  = drive ? OE_MASK : 8'h00;
  assign bus.uio_out = drive ? ((owner_q ? bus.wdata1 : bus.wdata0) & OE_MASK) : 8'h00;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter with default parameters (HOLD_MAX=8, TA_CYCLES=1, mask FF).
// Cycle cN is the interval after the Nth rising edge of a scenario; c0 is where requests appear.
module tb_uio_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic ena;
  int   total = 0;
  int   bad   = 0;

  uio_bus_arbiter_if bus ();

  uio_bus_arbiter dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req0   = 1'b0;
    bus.dir0   = 1'b0;
    bus.wdata0 = 8'h00;
    bus.req1   = 1'b0;
    bus.dir1   = 1'b0;
    bus.wdata1 = 8'h00;
    bus.uio_in = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    ena = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    clear_inputs();

    // 1: reset with random inputs, two cycles.
    bus.req0   = 1'($urandom);
    bus.req1   = 1'($urandom);
    bus.dir0   = 1'($urandom);
    bus.dir1   = 1'($urandom);
    bus.wdata0 = 8'($urandom);
    bus.wdata1 = 8'($urandom);
    bus.uio_in = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_gnt0", 8'(bus.gnt0), 8'h00);
      chk("rst_gnt1", 8'(bus.gnt1), 8'h00);
      chk("rst_busy", 8'(bus.busy), 8'h00);
      chk("rst_rvalid", 8'(bus.rvalid), 8'h00);
      chk("rst_rdata", bus.rdata, 8'h00);
      chk("rst_oe", bus.uio_oe, 8'h00);
      chk("rst_out", bus.uio_out, 8'h00);
    end
    rst = 1'b0;
    clear_inputs();

    // 2: single write grant, release on request drop.
    do_reset();
    bus.req0 = 1'b1; bus.dir0 = 1'b1; bus.wdata0 = 8'hA5;
    tick();  // c1
    chk("wr_c1_busy", 8'(bus.busy), 8'h01);
    chk("wr_c1_gnt0", 8'(bus.gnt0), 8'h00);
    chk("wr_c1_oe", bus.uio_oe, 8'h00);
    tick();  // c2
    chk("wr_c2_gnt0", 8'(bus.gnt0), 8'h01);
    chk("wr_c2_oe", bus.uio_oe, 8'hFF);
    chk("wr_c2_out", bus.uio_out, 8'hA5);
    tick();  // c3
    tick();  // c4
    chk("wr_c4_gnt0", 8'(bus.gnt0), 8'h01);
    bus.req0 = 1'b0;
    tick();  // c5
    chk("wr_c5_gnt0", 8'(bus.gnt0), 8'h00);
    chk("wr_c5_oe", bus.uio_oe, 8'h00);
    chk("wr_c5_busy", 8'(bus.busy), 8'h00);

    // 3: both continuous -> alternating 8-cycle grants with one turnaround cycle.
    do_reset();
    bus.req0 = 1'b1; bus.dir0 = 1'b1; bus.wdata0 = 8'h11;
    bus.req1 = 1'b1; bus.dir1 = 1'b1; bus.wdata1 = 8'h22;
    tick();  // c1
    chk("rr_c1_oe", bus.uio_oe, 8'h00);
    for (int c = 2; c <= 9; c++) begin
      tick();
      chk($sformatf("rr_c%0d_gnt0", c), 8'(bus.gnt0), 8'h01);
      chk($sformatf("rr_c%0d_gnt1", c), 8'(bus.gnt1), 8'h00);
      chk($sformatf("rr_c%0d_out", c), bus.uio_out, 8'h11);
    end
    tick();  // c10
    chk("rr_c10_gnt0", 8'(bus.gnt0), 8'h00);
    chk("rr_c10_gnt1", 8'(bus.gnt1), 8'h00);
    chk("rr_c10_oe", bus.uio_oe, 8'h00);
    chk("rr_c10_busy", 8'(bus.busy), 8'h01);
    for (int c = 11; c <= 18; c++) begin
      tick();
      chk($sformatf("rr_c%0d_gnt1", c), 8'(bus.gnt1), 8'h01);
      chk($sformatf("rr_c%0d_gnt0", c), 8'(bus.gnt0), 8'h00);
      chk($sformatf("rr_c%0d_out", c), bus.uio_out, 8'h22);
    end
    tick();  // c19
    chk("rr_c19_gnt1", 8'(bus.gnt1), 8'h00);
    chk("rr_c19_oe", bus.uio_oe, 8'h00);
    tick();  // c20
    chk("rr_c20_gnt0", 8'(bus.gnt0), 8'h01);
    chk("rr_c20_out", bus.uio_out, 8'h11);

    // 4: read grant, pads never driven, direction latched for the grant.
    do_reset();
    bus.req1 = 1'b1; bus.dir1 = 1'b0; bus.uio_in = 8'h3C; bus.wdata1 = 8'h99;
    tick();  // c1
    chk("rd_c1_oe", bus.uio_oe, 8'h00);
    tick();  // c2
    chk("rd_c2_gnt1", 8'(bus.gnt1), 8'h01);
    chk("rd_c2_oe", bus.uio_oe, 8'h00);
    chk("rd_c2_rvalid", 8'(bus.rvalid), 8'h00);
    tick();  // c3
    chk("rd_c3_rdata", bus.rdata, 8'h3C);
    chk("rd_c3_rvalid", 8'(bus.rvalid), 8'h01);
    bus.dir1 = 1'b1; bus.wdata1 = 8'hFF; bus.uio_in = 8'h5A;
    #1;
    chk("rd_c3_oe_flip", bus.uio_oe, 8'h00);
    tick();  // c4
    chk("rd_c4_oe", bus.uio_oe, 8'h00);
    chk("rd_c4_out", bus.uio_out, 8'h00);
    chk("rd_c4_rdata", bus.rdata, 8'h5A);
    bus.req1 = 1'b0;
    tick();  // c5
    chk("rd_c5_gnt1", 8'(bus.gnt1), 8'h00);
    chk("rd_c5_rvalid", 8'(bus.rvalid), 8'h01);
    tick();  // c6
    chk("rd_c6_rvalid", 8'(bus.rvalid), 8'h00);
    chk("rd_c6_rdata", bus.rdata, 8'h5A);

    // 5: ena drop mid write grant.
    do_reset();
    bus.req0 = 1'b1; bus.dir0 = 1'b1; bus.wdata0 = 8'hC3;
    tick(); tick(); tick(); tick();  // c4
    chk("en_c4_oe", bus.uio_oe, 8'hFF);
    chk("en_c4_out", bus.uio_out, 8'hC3);
    ena = 1'b0;
    #1;
    chk("en_c4_oe_off", bus.uio_oe, 8'h00);
    chk("en_c4_out_off", bus.uio_out, 8'h00);
    for (int c = 5; c <= 7; c++) begin
      tick();
      chk($sformatf("en_c%0d_gnt0", c), 8'(bus.gnt0), 8'h00);
      chk($sformatf("en_c%0d_busy", c), 8'(bus.busy), 8'h00);
    end
    ena = 1'b1;
    tick();
    chk("en_re_busy", 8'(bus.busy), 8'h01);
    tick();
    chk("en_re_gnt0", 8'(bus.gnt0), 8'h01);

    // 6: reset mid-OWN, then tie goes to requester 0.
    do_reset();
    bus.req0 = 1'b1; bus.dir0 = 1'b1; bus.wdata0 = 8'h5A;
    tick(); tick(); tick();  // c3
    chk("mr_c3_oe", bus.uio_oe, 8'hFF);
    bus.req1 = 1'b1; bus.dir1 = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_oe", bus.uio_oe, 8'h00);
    chk("mr_gnt0", 8'(bus.gnt0), 8'h00);
    chk("mr_gnt1", 8'(bus.gnt1), 8'h00);
    chk("mr_busy", 8'(bus.busy), 8'h00);
    tick();
    chk("mr_turn_busy", 8'(bus.busy), 8'h01);
    tick();
    chk("mr_tie_gnt0", 8'(bus.gnt0), 8'h01);
    chk("mr_tie_gnt1", 8'(bus.gnt1), 8'h00);

    // 7: request withdrawn during turnaround -> no grant.
    do_reset();
    bus.req0 = 1'b1; bus.dir0 = 1'b1;
    tick();  // c1
    bus.req0 = 1'b0;
    tick();  // c2
    chk("tl_gnt0", 8'(bus.gnt0), 8'h00);
    chk("tl_busy", 8'(bus.busy), 8'h00);
    chk("tl_oe", bus.uio_oe, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
